// File: rtl/ctl_axil_slave.sv
// ctl_axil_slave: AXI4-Lite control-plane responder for the accelerator.
// Holds MODE/CFG, issues a one-cycle start pulse to the core and exposes
// busy/done/error status. Optional macro CTL_IRQ_EN adds the oCTL_IRQ output
// and the IRQ_EN register at word 5.
module ctl_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] PRM_VERSION        = 32'h2025_0613
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [1:0]                      oCTL_MODE,
  output logic [1:0]                      oCTL_Q,
  output logic [1:0]                      oCTL_BUT,
  output logic                            oCTL_START,
`ifdef CTL_IRQ_EN
  output logic                            oCTL_IRQ,
`endif
  input  logic                            iCTL_BUSY,
  input  logic                            iCTL_DONE
);

  // Write-channel state: independent AW/W latches plus the pending response.
  logic       aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [2:0] aw_idx_q, aw_idx_d;
  logic [3:0] wdata_q, wdata_d;
  logic       wbe0_q, wbe0_d;
  logic       bvalid_q, bvalid_d;
  // Control/status registers.
  logic [1:0] mode_q, mode_d;
  logic [3:0] cfg_q, cfg_d;
  logic       done_q, done_d, err_q, err_d, done_prev_q;
  logic       start_pend_q, start_pend_d, start_q;
  // Read-channel state.
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
`ifdef CTL_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q;
`endif

  logic       aw_hs, w_hs, ar_hs, commit, done_rise;
  logic [2:0] wr_idx, ar_idx;
  logic [3:0] wr_data;
  logic       wr_be0;

  // Ready is offered only while the channel is empty and no response is
  // outstanding; gating with reset keeps every ready low while in reset.
  assign s00_axi_awready = s00_axi_aresetn & s00_axi_awvalid & ~aw_lat_q & ~bvalid_q;
  assign s00_axi_wready  = s00_axi_aresetn & s00_axi_wvalid & ~w_lat_q & ~bvalid_q;
  assign s00_axi_arready = s00_axi_aresetn & s00_axi_arvalid & ~rvalid_q;
  assign aw_hs = s00_axi_awready;
  assign w_hs  = s00_axi_wready;
  assign ar_hs = s00_axi_arready;

  // Bypass the latches when the beat handshakes in the commit cycle itself.
  assign wr_idx  = aw_lat_q ? aw_idx_q : s00_axi_awaddr[4:2];
  assign wr_data = w_lat_q ? wdata_q : s00_axi_wdata[3:0];
  assign wr_be0  = w_lat_q ? wbe0_q : s00_axi_wstrb[0];
  assign commit  = ~bvalid_q & (aw_lat_q | aw_hs) & (w_lat_q | w_hs);
  assign ar_idx  = s00_axi_araddr[4:2];
  assign done_rise = iCTL_DONE & ~done_prev_q;

  // Write-channel bookkeeping and register commit with its side effects.
  always_comb begin
    aw_lat_d     = aw_lat_q;
    w_lat_d      = w_lat_q;
    aw_idx_d     = aw_idx_q;
    wdata_d      = wdata_q;
    wbe0_d       = wbe0_q;
    bvalid_d     = bvalid_q;
    mode_d       = mode_q;
    cfg_d        = cfg_q;
    start_pend_d = 1'b0;
    done_d       = done_rise | done_q;
    err_d        = err_q;
`ifdef CTL_IRQ_EN
    irq_en_d     = irq_en_q;
`endif
    if (aw_hs) begin
      aw_lat_d = 1'b1;
      aw_idx_d = s00_axi_awaddr[4:2];
    end
    if (w_hs) begin
      w_lat_d = 1'b1;
      wdata_d = s00_axi_wdata[3:0];
      wbe0_d  = s00_axi_wstrb[0];
    end
    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      case (wr_idx)
        3'd0: begin
          if (iCTL_BUSY) err_d = 1'b1;
          else if (wr_be0) begin
            mode_d       = wr_data[1:0];
            start_pend_d = |wr_data[1:0];
          end
        end
        3'd1: begin
          if (iCTL_BUSY) err_d = 1'b1;
          else if (wr_be0) cfg_d = wr_data;
        end
        3'd3: begin
          // A fresh done edge in the same cycle overrides the clear.
          if (wr_be0 && wr_data[0]) done_d = done_rise;
          if (wr_be0 && wr_data[1]) err_d = 1'b0;
        end
`ifdef CTL_IRQ_EN
        3'd5: if (wr_be0) irq_en_d = wr_data[0];
`endif
        default: ;
      endcase
    end
  end

  // Read-data mux sampled at the AR handshake, so it sees pre-commit values.
  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      3'd0: rd_mux[1:0] = mode_q;
      3'd1: rd_mux[3:0] = cfg_q;
      3'd2: rd_mux[2:0] = {err_q, done_q, iCTL_BUSY};
      3'd4: rd_mux = PRM_VERSION;
`ifdef CTL_IRQ_EN
      3'd5: rd_mux[0] = irq_en_q;
`endif
      default: ;
    endcase
    rdata_d  = ar_hs ? rd_mux : rdata_q;
    rvalid_d = ar_hs ? 1'b1 : (s00_axi_rready ? 1'b0 : rvalid_q);
  end

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_lat_q     <= 1'b0;
      w_lat_q      <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wbe0_q       <= 1'b0;
      bvalid_q     <= 1'b0;
      mode_q       <= '0;
      cfg_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_prev_q  <= 1'b0;
      start_pend_q <= 1'b0;
      start_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
`ifdef CTL_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      aw_lat_q     <= aw_lat_d;
      w_lat_q      <= w_lat_d;
      aw_idx_q     <= aw_idx_d;
      wdata_q      <= wdata_d;
      wbe0_q       <= wbe0_d;
      bvalid_q     <= bvalid_d;
      mode_q       <= mode_d;
      cfg_q        <= cfg_d;
      done_q       <= done_d;
      err_q        <= err_d;
      done_prev_q  <= iCTL_DONE;
      start_pend_q <= start_pend_d;
      start_q      <= start_pend_q;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
`ifdef CTL_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_q        <= done_q & irq_en_q;
`endif
    end
  end

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rresp  = 2'b00;
  assign oCTL_MODE  = mode_q;
  assign oCTL_Q     = cfg_q[3:2];
  assign oCTL_BUT   = cfg_q[1:0];
  assign oCTL_START = start_q;
`ifdef CTL_IRQ_EN
  assign oCTL_IRQ   = irq_q;
`endif

  // Inputs that carry no meaning for this register map.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:4],
                       s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_ctl_axil_slave.sv
// Directed testbench for ctl_axil_slave (build with +define+CTL_IRQ_EN to
// exercise the interrupt option).
module tb_ctl_axil_slave;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp, mode, q, but;
  logic        start, busy, done;
`ifdef CTL_IRQ_EN
  logic        irq;
`endif
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  ctl_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .oCTL_MODE(mode), .oCTL_Q(q), .oCTL_BUT(but),
    .oCTL_START(start),
`ifdef CTL_IRQ_EN
    .oCTL_IRQ(irq),
`endif
    .iCTL_BUSY(busy), .iCTL_DONE(done)
  );

  always @(posedge clk) if (start) start_cnt <= start_cnt + 1;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic ag, wg;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      #1; ag = awready; wg = wready;
      tick;
      if (ag) awvalid = 0;
      if (wg) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) begin
      checks++; errors++; $display("FAIL wr_accept_timeout addr=%0h", a);
      awvalid = 0; wvalid = 0;
    end
    n = 0;
    while (!bvalid && n < 20) begin tick; n++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL wr_bvalid_timeout addr=%0h", a); end
    tick;
    $display("WR addr=%02h data=%08h strb=%h", a, d, s);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1; rready = 1; n = 0;
    #1;
    while (!arready && n < 20) begin tick; n++; end
    if (!arready) begin checks++; errors++; $display("FAIL rd_arready_timeout addr=%0h", a); end
    tick; arvalid = 0; n = 0;
    while (!rvalid && n < 20) begin tick; n++; end
    if (!rvalid) begin checks++; errors++; $display("FAIL rd_rvalid_timeout addr=%0h", a); end
    d = rdata;
    tick;
    $display("RD addr=%02h data=%08h", a, d);
  endtask

  task automatic test_reset;
    aresetn = 0; awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 4'hF; awprot = 0; arprot = 0;
    busy = 0; done = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL rst_ready got %b exp 000", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", {bvalid, rvalid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if ({mode, q, but, start} !== 7'h0) begin errors++; $display("FAIL rst_ctl got %h exp 0", {mode, q, but, start}); end
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick; aresetn = 1; tick;
    $display("RESET released");
  endtask

  task automatic test_aw_w_together;
    awaddr = 5'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    #1;
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL t1_ready got %b exp 11", {awready, wready}); end
    tick; awvalid = 0; wvalid = 0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t1_bvalid got %b exp 1", bvalid); end
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL t1_mode got %0d exp 2", mode); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL t1_start_early got %b exp 0", start); end
    tick;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL t1_start got %b exp 1", start); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t1_bvalid_clear got %b exp 0", bvalid); end
    tick;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL t1_start_width got %b exp 0", start); end
    $display("WR addr=00 data=00000002 (AW/W together)");
  endtask

  task automatic test_back_to_back;
    int s0;
    s0 = start_cnt;
    awaddr = 5'h04; wdata = 32'h4; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    #1;
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL t2_ready got %b exp 11", {awready, wready}); end
    tick;
    checks++; if ({q, but} !== 4'b0100) begin errors++; $display("FAIL t2_cfg got %b exp 0100", {q, but}); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL t2_bhold cyc%0d got %b exp 100", i, {bvalid, awready, wready}); end
      if (i == 4) bready = 1; else tick;
    end
    tick;
    checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL t2_second_accept got %b exp 011", {bvalid, awready, wready}); end
    tick; awvalid = 0; wvalid = 0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t2_second_bvalid got %b exp 1", bvalid); end
    repeat (3) tick;
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL t2_no_start got %0d exp 0", start_cnt - s0); end
    $display("WR addr=04 data=00000004 x2 (back-to-back, bready stalled)");
  endtask

  task automatic test_aw_then_w;
    int s0;
    s0 = start_cnt;
    awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL t3_awready got %b exp 1", awready); end
    tick; awvalid = 0;
    tick; tick; wvalid = 1; #1;
    checks++; if ({wready, bvalid} !== 2'b10) begin errors++; $display("FAIL t3_w_accept got %b exp 10", {wready, bvalid}); end
    tick; wvalid = 0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t3_bvalid got %b exp 1", bvalid); end
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL t3_mode got %0d exp 1", mode); end
    repeat (3) tick;
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t3_start_count got %0d exp 1", start_cnt - s0); end
    $display("WR addr=00 data=00000001 (AW first, W three cycles later)");
  endtask

  task automatic test_busy_err;
    logic [31:0] d;
    int s0;
    s0 = start_cnt;
    busy = 1;
    axi_write(5'h00, 32'h2, 4'hF);
    axi_write(5'h04, 32'hF, 4'hF);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL t4_mode_kept got %0d exp 1", mode); end
    checks++; if ({q, but} !== 4'b0100) begin errors++; $display("FAIL t4_cfg_kept got %b exp 0100", {q, but}); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL t4_status_err got %h exp 5", d); end
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL t4_status_clr got %h exp 1", d); end
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL t4_no_start got %0d exp 0", start_cnt - s0); end
    busy = 0;
  endtask

  task automatic test_done_and_read;
    logic [31:0] d;
    done = 1; tick; done = 0; tick;
    axi_read(5'h08, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL t5_done_set got %h exp 2", d); end
    // Drop done so the next assertion is a fresh edge, coinciding with the CLR commit.
    tick;
    awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; done = 1;
    #1;
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL t5_clr_ready got %b exp 11", {awready, wready}); end
    tick; awvalid = 0; wvalid = 0; done = 0;
    tick;
    $display("WR addr=0c data=00000001 (with coincident done edge)");
    axi_read(5'h08, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL t5_set_wins got %h exp 2", d); end
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t5_done_clr got %h exp 0", d); end
    axi_write(5'h04, 32'hF, 4'h0);
    checks++; if ({q, but} !== 4'b0100) begin errors++; $display("FAIL t5_strobe_off got %b exp 0100", {q, but}); end
    axi_read(5'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t5_clr_reads0 got %h exp 0", d); end
    axi_read(5'h1C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t5_unmapped got %h exp 0", d); end
    araddr = 5'h10; arvalid = 1; rready = 0;
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL t5_arready got %b exp 1", arready); end
    tick; arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rvalid, rdata} !== {1'b1, 32'h2025_0613}) begin errors++; $display("FAIL t5_rhold cyc%0d got %b/%h exp 1/20250613", i, rvalid, rdata); end
      if (i == 2) rready = 1; else tick;
    end
    tick;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL t5_rvalid_clear got %b exp 0", rvalid); end
    $display("RD addr=10 data=20250613 (rready stalled)");
  endtask

`ifdef CTL_IRQ_EN
  task automatic test_irq;
    axi_write(5'h14, 32'h1, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    done = 1; tick; done = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got %b exp 0", irq); end
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
  endtask
`endif

  task automatic test_reset_midflight;
    logic [31:0] d;
    awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    tick; awvalid = 0; wvalid = 0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t6_pre_bvalid got %b exp 1", bvalid); end
    aresetn = 0; #1;
    checks++; if ({bvalid, mode, q, but} !== 7'h0) begin errors++; $display("FAIL t6_async_clear got %h exp 0", {bvalid, mode, q, but}); end
`ifdef CTL_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t6_irq got %b exp 0", irq); end
`endif
    tick; tick; aresetn = 1; bready = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t6_stale_b cyc%0d got %b exp 0", i, bvalid); end
    end
    axi_read(5'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_cfg_after got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_aw_w_together();
    test_back_to_back();
    test_aw_then_w();
    test_busy_err();
    test_done_and_read();
`ifdef CTL_IRQ_EN
    test_irq();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctl_axil_slave.md
Name: ctl_axil_slave

Overview:
- AXI4-Lite responder for the accelerator control plane: the slave end of the 5-bit-address, 32-bit-data control channel that the host/bench drives.
- Holds MODE (1 = KECCAK, 2 = PWM) and CFG ({Q[1:0], BUT[1:0]}) registers.
- Issues a one-cycle start pulse to the core datapath and exposes busy/done/error status for readback.
- Sits inside MDL between the s00_axi port and the Keccak/PWM datapath controller.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, AXI-Lite byte address width; word index = addr[4:2].
- PRM_VERSION, 32'h2025_0613, value returned by the read-only VERSION register.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  5  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1  write address valid
- s00_axi_awready  out  1  write address accepted
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte strobes; a byte lane updates only when its strobe is 1
- s00_axi_wvalid  in  1  write data valid
- s00_axi_wready  out  1  write data accepted
- s00_axi_bresp  out  2  always 2'b00 (OKAY)
- s00_axi_bvalid  out  1  write response valid
- s00_axi_bready  in  1  write response accept
- s00_axi_araddr  in  5  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1  read address valid
- s00_axi_arready  out  1  read address accepted
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid  out  1  read data valid
- s00_axi_rready  in  1  read data accept
- oCTL_MODE  out  2  MODE[1:0]
- oCTL_Q  out  2  CFG[3:2]
- oCTL_BUT  out  2  CFG[1:0]
- oCTL_START  out  1  one-cycle start pulse
- iCTL_BUSY  in  1  core busy level
- iCTL_DONE  in  1  core done; level or pulse, edge-detected

Behaviour:

Reset (asynchronous, active-low):
- All ready/valid outputs are 0; rdata = 0.
- MODE = 0, CFG = 0, oCTL_START = 0.
- Status stickies cleared; done edge-detect register cleared.
- Reset mid-transaction drops the transaction; no response is issued after release.

Register map (addr[4:2]):
- 0 MODE: RW, bits[1:0].
- 1 CFG: RW, bits[3:0].
- 2 STATUS: RO, {29'd0, ERR, DONE, iCTL_BUSY}.
- 3 CLR: write-1-to-clear; bit0 clears DONE, bit1 clears ERR; reads 0.
- 4 VERSION: RO.
- 5-7: unmapped; reads 0, writes ignored.
- Writes to RO or unmapped addresses still return OKAY.

Write channel (AW and W independent, each latched once):
- awready is a one-cycle pulse when awvalid=1, AW not yet latched, and bvalid=0. wready behaves the same way for W.
- AW and W arriving in the same cycle are both accepted in that cycle.
- Commit happens on the cycle after both are latched. bvalid rises in the same cycle as commit. Best case: handshake at N, register and bvalid at N+1.
- bvalid holds until bready=1; the AW/W latches clear then. No new AW/W is accepted while bvalid=1.
- Back-to-back writes with awvalid/wvalid held high: the second write is accepted the cycle after bready completes the first.

Write side effects:
- MODE or CFG written while iCTL_BUSY=1: write ignored, ERR set.
- MODE written with nonzero value while iCTL_BUSY=0: oCTL_START=1 for exactly the cycle after commit.
- Writing 0 to MODE: no start.

Read channel:
- arready is a one-cycle pulse when arvalid=1 and rvalid=0.
- rdata is registered at the handshake; rvalid=1 the next cycle and holds with stable rdata until rready=1.
- Read and write run concurrently. A read handshaking in the same cycle as a write commit returns the pre-write value.

DONE/ERR:
- Rising edge of iCTL_DONE (registered compare) sets DONE.
- CLR write sets/clears per the register map.
- Set and clear in the same cycle: set wins.

Optional Feature:
- Macro CTL_IRQ_EN.
- Defined:
  - adds port oCTL_IRQ (out, 1) and register 5 IRQ_EN (RW, bit0, reset 0);
  - oCTL_IRQ = registered (DONE & IRQ_EN), asserted 1 cycle after DONE sets; deasserts 1 cycle after DONE is cleared.
- Undefined: no oCTL_IRQ port; register 5 behaves as unmapped.

Test Plan:
1. Reset, then AW/W together addr 0x00 data 2, bready=1 -> awready/wready pulse at N, bvalid at N+1, oCTL_MODE=2, oCTL_START high 1 cycle at N+2.
2. Immediately write addr 0x04 data 0x4 with awvalid/wvalid held, bready dropped for 5 cycles before being raised -> bvalid held 5 cycles; oCTL_Q=2'b01, oCTL_BUT=2'b00 after commit; no START.
3. AW at cycle N, W at N+3 (addr 0x00, data 1) -> commit and bvalid at N+4; MODE=1; START pulse once.
4. iCTL_BUSY=1, write MODE=2 -> MODE unchanged, STATUS read = 0x5 (ERR=1, BUSY=1); write CLR=0x2 -> STATUS read = 0x1 (BUSY=1).
5. Pulse iCTL_DONE, read 0x08 -> 0x2. Then, in the same cycle, pulse iCTL_DONE again and commit CLR=0x1 -> DONE stays 1. Read 0x10 with rready low for 3 cycles -> rdata stable at 32'h20250613 until accepted.
6. Assert s00_axi_aresetn=0 while bvalid=1 -> bvalid, MODE, CFG return to 0 immediately; after release, no stale response; with CTL_IRQ_EN defined, oCTL_IRQ=0.
